// File: rtl/fm_phase_discriminator_if.sv
// Bundle between the CORDIC phase/modulus stream and the FM discriminator.
// The master drives the phase stream and squelch threshold; the slave
// (the discriminator) returns the decimated audio, its strobe and the squelch flag.
interface fm_phase_discriminator_if #(
    parameter int PH_BITS   = 32,
    parameter int MOD_WIDTH = 12,
    parameter int OUT_WIDTH = 24
);
    logic [PH_BITS-1:0]          phase_in;
    logic                        phase_valid;
    logic [MOD_WIDTH-1:0]        modulus_in;
    logic [MOD_WIDTH-1:0]        squelch_thr;
    logic signed [OUT_WIDTH-1:0] audio_out;
    logic                        audio_valid;
    logic                        squelch_active;

    modport master (
        output phase_in, phase_valid, modulus_in, squelch_thr,
        input  audio_out, audio_valid, squelch_active
    );

    modport slave (
        input  phase_in, phase_valid, modulus_in, squelch_thr,
        output audio_out, audio_valid, squelch_active
    );
endinterface

// File: rtl/fm_phase_discriminator.sv
// FM phase discriminator: differences consecutive CORDIC phase words (wrapping
// modulo 2^PH_BITS), sums DECIM differences per block and emits the top
// OUT_WIDTH bits of the sum as one audio sample. A block in which at least half
// of the samples had a modulus below the squelch threshold is muted.
module fm_phase_discriminator #(
    parameter int PH_BITS   = 32,
    parameter int MOD_WIDTH = 12,
    parameter int DECIM     = 64,
    parameter int OUT_WIDTH = 24
) (
    input  logic                   clk_in,
    input  logic                   RST,
    fm_phase_discriminator_if.slave bus
);
    localparam int LOG2_DECIM = $clog2(DECIM);
    localparam int ACC_W      = PH_BITS + LOG2_DECIM;
    localparam int CNT_W      = LOG2_DECIM + 1;

    // Stage 1 state
    logic [PH_BITS-1:0]        r_prev_phase;
    logic                      r_primed;
    logic [PH_BITS-1:0]        r_diff;
    logic                      r_low;
    logic                      r_s1_valid;

    // Stage 2 state
    logic [ACC_W-1:0]          r_acc;
    logic [CNT_W-1:0]          r_low_cnt;
    logic [LOG2_DECIM-1:0]     r_count;
    logic [OUT_WIDTH-1:0]      r_audio;
    logic                      r_audio_valid;
    logic                      r_squelch;

    // Stage 2 combinational helpers
    logic [ACC_W-1:0]          w_diff_ext;
    logic [ACC_W-1:0]          w_sum;
    logic [CNT_W-1:0]          w_low_total;
    logic                      w_last;
    logic                      w_mute;

    // The phase difference is a signed angle step; sign-extend it into the
    // wider accumulator so a block of DECIM steps can never overflow.
    assign w_diff_ext  = {{LOG2_DECIM{r_diff[PH_BITS-1]}}, r_diff};
    assign w_sum       = r_acc + w_diff_ext;
    assign w_low_total = r_low_cnt + {{LOG2_DECIM{1'b0}}, r_low};
    assign w_last      = (r_count == LOG2_DECIM'(DECIM - 1));
    assign w_mute      = (w_low_total >= CNT_W'(DECIM / 2));

    // Stage 1: wrapped phase difference and low-signal flag for each valid sample
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            r_prev_phase <= '0;
            r_primed     <= 1'b0;
            r_diff       <= '0;
            r_low        <= 1'b0;
            r_s1_valid   <= 1'b0;
        end else begin
            r_s1_valid <= bus.phase_valid;
            if (bus.phase_valid) begin
                // The first sample after reset has no predecessor, so it
                // contributes zero but still counts toward the block.
                r_diff       <= r_primed ? (bus.phase_in - r_prev_phase) : '0;
                r_prev_phase <= bus.phase_in;
                r_primed     <= 1'b1;
                r_low        <= (bus.modulus_in < bus.squelch_thr);
            end
        end
    end

    // Stage 2: block accumulation, output truncation and squelch decision
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            r_acc         <= '0;
            r_low_cnt     <= '0;
            r_count       <= '0;
            r_audio       <= '0;
            r_audio_valid <= 1'b0;
            r_squelch     <= 1'b0;
        end else begin
            r_audio_valid <= 1'b0;
            if (r_s1_valid) begin
                if (w_last) begin
                    // Last sample of the block is folded in here; the output is
                    // plain truncation of the top bits, no rounding.
                    r_audio_valid <= 1'b1;
                    r_squelch     <= w_mute;
                    r_audio       <= w_mute ? '0 : w_sum[ACC_W-1 -: OUT_WIDTH];
                    r_acc         <= '0;
                    r_low_cnt     <= '0;
                    r_count       <= '0;
                end else begin
                    r_acc     <= w_sum;
                    r_low_cnt <= w_low_total;
                    r_count   <= r_count + 1'b1;
                end
            end
        end
    end

    assign bus.audio_out      = r_audio;
    assign bus.audio_valid    = r_audio_valid;
    assign bus.squelch_active = r_squelch;
endmodule
